// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, datapath
// select/opcode encodings, decoded instruction classes and opcode/funct values.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100
    } state_t;

    typedef enum logic [3:0] {
        CLS_RALU,
        CLS_SHIFT,
        CLS_JR,
        CLS_J,
        CLS_JAL,
        CLS_BEQ,
        CLS_BNE,
        CLS_ADDI,
        CLS_ORI,
        CLS_LW,
        CLS_SW,
        CLS_ILL
    } iclass_t;

    // Register file destination select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] ALUSRC_REG  = 2'b00;
    localparam logic [1:0] ALUSRC_IMM  = 2'b01;
    localparam logic [1:0] ALUSRC_SHA  = 2'b10;
    localparam logic [1:0] ALUSRC_ZERO = 2'b11;

    // Register file write-data select
    localparam logic [1:0] DM2REG  = 2'b00;
    localparam logic [1:0] ALU2REG = 2'b01;
    localparam logic [1:0] NPC2REG = 2'b10;

    // Next-PC select
    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    // ALU operation
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // R-type results go to rd; everything else that writes back uses rt
    function automatic logic writes_rd(input iclass_t cls);
        return (cls == CLS_RALU) || (cls == CLS_SHIFT);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, strobes,
// selects and the retired-instruction count out.
interface mc_ctrl_if;

    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        mem_ready;

    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  RegDst;
    logic [1:0]  ALUSrc;
    logic [1:0]  ToReg;
    logic [1:0]  NPCOp;
    logic [3:0]  ALUOp;
    logic        illegal;
    logic [31:0] retired;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
        output RegDst, ALUSrc, ToReg, NPCOp, ALUOp, illegal, retired
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
        input  RegDst, ALUSrc, ToReg, NPCOp, ALUOp, illegal, retired
    );

endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decoder: maps Op/Funct to an instruction class,
// the ALU operation that class needs, and an illegal-instruction flag.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic [3:0] aluop,
    output logic       illegal
);

    // Classify the instruction; anything outside the decoded set is illegal
    always_comb begin
        cls   = CLS_ILL;
        aluop = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin cls = CLS_RALU;  aluop = ALU_ADD; end
                    FN_SUB:  begin cls = CLS_RALU;  aluop = ALU_SUB; end
                    FN_AND:  begin cls = CLS_RALU;  aluop = ALU_AND; end
                    FN_OR:   begin cls = CLS_RALU;  aluop = ALU_OR;  end
                    FN_SLT:  begin cls = CLS_RALU;  aluop = ALU_SLT; end
                    FN_SLL:  begin cls = CLS_SHIFT; aluop = ALU_SLL; end
                    FN_SRL:  begin cls = CLS_SHIFT; aluop = ALU_SRL; end
                    FN_JR:   begin cls = CLS_JR; end
                    default: begin cls = CLS_ILL; end
                endcase
            end
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            OP_BEQ:  begin cls = CLS_BEQ;  aluop = ALU_SUB; end
            OP_BNE:  begin cls = CLS_BNE;  aluop = ALU_SUB; end
            OP_ADDI: begin cls = CLS_ADDI; aluop = ALU_ADD; end
            OP_ORI:  begin cls = CLS_ORI;  aluop = ALU_OR;  end
            OP_LW:   begin cls = CLS_LW;   aluop = ALU_ADD; end
            OP_SW:   begin cls = CLS_SW;   aluop = ALU_ADD; end
            default: cls = CLS_ILL;
        endcase
    end

    assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencer that
// drives datapath strobes and selects, and counts retired instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    mc_ctrl_if.master bus
);

    state_t      state;
    state_t      next_state;
    iclass_t     cls;
    logic [3:0]  dec_aluop;
    logic        dec_illegal;

    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal_pulse;
    logic [1:0]  reg_dst;
    logic [1:0]  alu_src;
    logic [1:0]  to_reg;
    logic [1:0]  npc_op;
    logic [3:0]  alu_op;
    logic        retire;
    logic [31:0] retired_q;

    mc_ctrl_dec u_dec (
        .op      (bus.Op),
        .funct   (bus.Funct),
        .cls     (cls),
        .aluop   (dec_aluop),
        .illegal (dec_illegal)
    );

    // State register; reset returns to FETCH and abandons any instruction
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode for the current state and instruction class
    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        illegal_pulse = 1'b0;
        reg_dst       = RD_RT;
        alu_src       = ALUSRC_REG;
        to_reg        = DM2REG;
        npc_op        = NPC_PLUS4;
        alu_op        = ALU_ADD;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    npc_op     = NPC_PLUS4;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                case (cls)
                    CLS_J: begin
                        pc_write   = 1'b1;
                        npc_op     = NPC_JUMP;
                        next_state = FETCH;
                    end
                    CLS_JAL: begin
                        pc_write   = 1'b1;
                        npc_op     = NPC_JUMP;
                        reg_write  = 1'b1;
                        reg_dst    = RD_RA;
                        to_reg     = NPC2REG;
                        next_state = FETCH;
                    end
                    CLS_JR: begin
                        pc_write   = 1'b1;
                        npc_op     = NPC_JR;
                        next_state = FETCH;
                    end
                    CLS_ILL: begin
                        illegal_pulse = dec_illegal;
                        next_state    = FETCH;
                    end
                    default: next_state = EXEC;
                endcase
            end
            EXEC: begin
                case (cls)
                    CLS_RALU: begin
                        alu_src    = ALUSRC_REG;
                        alu_op     = dec_aluop;
                        next_state = WB;
                    end
                    CLS_SHIFT: begin
                        alu_src    = ALUSRC_SHA;
                        alu_op     = dec_aluop;
                        next_state = WB;
                    end
                    CLS_ADDI, CLS_ORI: begin
                        alu_src    = ALUSRC_IMM;
                        alu_op     = dec_aluop;
                        next_state = WB;
                    end
                    CLS_LW, CLS_SW: begin
                        alu_src    = ALUSRC_IMM;
                        alu_op     = dec_aluop;
                        next_state = MEM;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        alu_src = ALUSRC_REG;
                        alu_op  = dec_aluop;
                        if ((cls == CLS_BEQ && bus.Zero) || (cls == CLS_BNE && !bus.Zero)) begin
                            pc_write = 1'b1;
                            npc_op   = NPC_BRANCH;
                        end
                        next_state = FETCH;
                    end
                    default: next_state = FETCH;
                endcase
            end
            MEM: begin
                case (cls)
                    CLS_LW: begin
                        mem_read = 1'b1;
                        if (bus.mem_ready) begin
                            next_state = WB;
                        end
                    end
                    CLS_SW: begin
                        mem_write = 1'b1;
                        if (bus.mem_ready) begin
                            next_state = FETCH;
                        end
                    end
                    default: next_state = FETCH;
                endcase
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = writes_rd(cls) ? RD_RD : RD_RT;
                to_reg     = (cls == CLS_LW) ? DM2REG : ALU2REG;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // An instruction retires when control returns to FETCH, except for an illegal one
    assign retire = (state != FETCH) && (next_state == FETCH) &&
                    !((state == DECODE) && dec_illegal);

    // Retired-instruction counter, wrapping naturally at 32 bits
    always_ff @(posedge clk) begin
        if (!rstn) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.PCWrite  = rstn & pc_write;
    assign bus.IRWrite  = rstn & ir_write;
    assign bus.RegWrite = rstn & reg_write;
    assign bus.MemRead  = rstn & mem_read;
    assign bus.MemWrite = rstn & mem_write;
    assign bus.illegal  = rstn & illegal_pulse;
    assign bus.RegDst   = rstn ? reg_dst : 2'b00;
    assign bus.ALUSrc   = rstn ? alu_src : 2'b00;
    assign bus.ToReg    = rstn ? to_reg  : 2'b00;
    assign bus.NPCOp    = rstn ? npc_op  : 2'b00;
    assign bus.ALUOp    = rstn ? alu_op  : 4'b0000;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: per-instruction expected output traces are generated
// from the instruction's phase sequence and compared every cycle.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mr;
        logic       mw;
        logic [1:0] regdst;
        logic [1:0] alusrc;
        logic [1:0] toreg;
        logic [1:0] npcop;
        logic [3:0] aluop;
        logic       ill;
    } outs_t;

    typedef struct {
        logic  mrdy;
        logic  rnd;
        outs_t o;
    } step_t;

    logic        clk;
    logic        rstn;
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_ret;
    step_t       exp_q[$];

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: return "add";
                6'b100010: return "sub";
                6'b100100: return "and";
                6'b100101: return "or";
                6'b101010: return "slt";
                6'b000000: return "sll";
                6'b000010: return "srl";
                6'b001000: return "jr";
                default:   return "ill";
            endcase
        end
        case (op)
            6'b000010: return "j";
            6'b000011: return "jal";
            6'b000100: return "beq";
            6'b000101: return "bne";
            6'b001000: return "addi";
            6'b001101: return "ori";
            6'b100011: return "lw";
            6'b101011: return "sw";
            default:   return "ill";
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input string k);
        if (k == "sub") return 4'b0001;
        if (k == "and") return 4'b0010;
        if (k == "or" || k == "ori") return 4'b0011;
        if (k == "slt") return 4'b0100;
        if (k == "sll") return 4'b0101;
        if (k == "srl") return 4'b0110;
        return 4'b0000;
    endfunction

    function automatic logic is_r(input string k);
        return k == "add" || k == "sub" || k == "and" || k == "or" ||
               k == "slt" || k == "sll" || k == "srl";
    endfunction

    task automatic push(input logic mrdy, input logic rnd, input outs_t o);
        step_t s;
        s.mrdy = mrdy;
        s.rnd  = rnd;
        s.o    = o;
        exp_q.push_back(s);
    endtask

    // Builds the expected per-cycle trace of one instruction and bumps the retire model
    task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
        string k;
        outs_t o;
        k = kind_of(op, fn);
        exp_q.delete();
        for (int i = 0; i < fw; i++) begin
            o = '0; o.mr = 1'b1;
            push(1'b0, 1'b0, o);
        end
        o = '0; o.mr = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; o.npcop = 2'b00;
        push(1'b1, 1'b0, o);
        o = '0;
        if (k == "ill") begin
            o.ill = 1'b1;
            push(1'b0, 1'b1, o);
            return;
        end
        if (k == "j" || k == "jal" || k == "jr") begin
            o.pcw   = 1'b1;
            o.npcop = (k == "jr") ? 2'b11 : 2'b10;
            if (k == "jal") begin
                o.rw = 1'b1; o.regdst = 2'b10; o.toreg = 2'b10;
            end
            push(1'b0, 1'b1, o);
            exp_ret++;
            return;
        end
        push(1'b0, 1'b1, o);
        o = '0;
        if (k == "beq" || k == "bne") begin
            o.aluop = 4'b0001;
            if ((k == "beq" && z) || (k == "bne" && !z)) begin
                o.pcw = 1'b1; o.npcop = 2'b01;
            end
            push(1'b0, 1'b1, o);
            exp_ret++;
            return;
        end
        if (k == "sll" || k == "srl") o.alusrc = 2'b10;
        else if (is_r(k))            o.alusrc = 2'b00;
        else                          o.alusrc = 2'b01;
        o.aluop = alu_code(k);
        push(1'b0, 1'b1, o);
        if (k == "lw" || k == "sw") begin
            for (int i = 0; i <= mw; i++) begin
                o = '0;
                if (k == "lw") o.mr = 1'b1;
                else           o.mw = 1'b1;
                push(i == mw, 1'b0, o);
            end
            if (k == "sw") begin
                exp_ret++;
                return;
            end
        end
        o = '0; o.rw = 1'b1;
        o.regdst = is_r(k) ? 2'b01 : 2'b00;
        o.toreg  = (k == "lw") ? 2'b00 : 2'b01;
        push(1'b0, 1'b1, o);
        exp_ret++;
    endtask

    task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.Op    = op;
        bus.Funct = fn;
        bus.Zero  = z;
    endtask

    // One clock: drive mem_ready, sample outputs at the falling edge, return after the rising edge
    task automatic step(input logic mrdy, input logic rnd, output outs_t obs);
        bus.mem_ready = rnd ? 1'($urandom_range(0, 1)) : mrdy;
        @(negedge clk);
        obs = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite,
               bus.RegDst, bus.ALUSrc, bus.ToReg, bus.NPCOp, bus.ALUOp, bus.illegal};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        outs_t obs;
        outs_t idle;
        rstn = 1'b0;
        drive_instr(6'b000000, 6'b100000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, obs);
            n_checks++;
            if (obs !== outs_t'('0)) begin
                n_fail++;
                $display("[TB] FAIL reset_outs cycle %0d: got %b expected %b", i, obs, outs_t'('0));
            end
        end
        rstn = 1'b1;
        exp_ret = '0;
        n_checks++;
        if (bus.retired !== exp_ret) begin
            n_fail++;
            $display("[TB] FAIL reset_retired: got %0d expected %0d", bus.retired, exp_ret);
        end
        idle = '0; idle.mr = 1'b1;
        step(1'b0, 1'b0, obs);
        n_checks++;
        if (obs !== idle) begin
            n_fail++;
            $display("[TB] FAIL reset_fetch_idle: got %b expected %b", obs, idle);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [7];
        outs_t obs;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
        foreach (fns[f]) begin
            drive_instr(6'b000000, fns[f], 1'($urandom_range(0, 1)));
            gen(6'b000000, fns[f], bus.Zero, 0, 0);
            foreach (exp_q[i]) begin
                step(exp_q[i].mrdy, exp_q[i].rnd, obs);
                n_checks++;
                if (obs !== exp_q[i].o) begin
                    n_fail++;
                    $display("[TB] FAIL rtype fn=%b cycle %0d: got %b expected %b", fns[f], i, obs, exp_q[i].o);
                end
            end
            n_checks++;
            if (bus.retired !== exp_ret) begin
                n_fail++;
                $display("[TB] FAIL rtype_retired fn=%b: got %0d expected %0d", fns[f], bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_lw_wait();
        outs_t obs;
        drive_instr(6'b100011, 6'($urandom), 1'b0);
        gen(6'b100011, bus.Funct, 1'b0, 0, 3);
        foreach (exp_q[i]) begin
            step(exp_q[i].mrdy, exp_q[i].rnd, obs);
            n_checks++;
            if (obs !== exp_q[i].o) begin
                n_fail++;
                $display("[TB] FAIL lw_wait cycle %0d: got %b expected %b", i, obs, exp_q[i].o);
            end
        end
        n_checks++;
        if (bus.retired !== exp_ret) begin
            n_fail++;
            $display("[TB] FAIL lw_wait_retired: got %0d expected %0d", bus.retired, exp_ret);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4];
        logic       zs  [4];
        outs_t obs;
        ops = '{6'b000100, 6'b000101, 6'b000100, 6'b000101};
        zs  = '{1'b1, 1'b1, 1'b0, 1'b0};
        foreach (ops[b]) begin
            drive_instr(ops[b], 6'($urandom), zs[b]);
            gen(ops[b], bus.Funct, zs[b], 0, 0);
            foreach (exp_q[i]) begin
                step(exp_q[i].mrdy, exp_q[i].rnd, obs);
                n_checks++;
                if (obs !== exp_q[i].o) begin
                    n_fail++;
                    $display("[TB] FAIL branch op=%b z=%b cycle %0d: got %b expected %b", ops[b], zs[b], i, obs, exp_q[i].o);
                end
            end
        end
        n_checks++;
        if (bus.retired !== exp_ret) begin
            n_fail++;
            $display("[TB] FAIL branch_retired: got %0d expected %0d", bus.retired, exp_ret);
        end
    endtask

    task automatic test_jump();
        logic [5:0] ops [3];
        logic [5:0] fns [3];
        outs_t obs;
        ops = '{6'b000011, 6'b000010, 6'b000000};
        fns = '{6'b010101, 6'b111000, 6'b001000};
        foreach (ops[j]) begin
            drive_instr(ops[j], fns[j], 1'b0);
            gen(ops[j], fns[j], 1'b0, 1, 0);
            foreach (exp_q[i]) begin
                step(exp_q[i].mrdy, exp_q[i].rnd, obs);
                n_checks++;
                if (obs !== exp_q[i].o) begin
                    n_fail++;
                    $display("[TB] FAIL jump op=%b cycle %0d: got %b expected %b", ops[j], i, obs, exp_q[i].o);
                end
            end
            n_checks++;
            if (bus.retired !== exp_ret) begin
                n_fail++;
                $display("[TB] FAIL jump_retired op=%b: got %0d expected %0d", ops[j], bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        outs_t obs;
        ops = '{6'b111111, 6'b000000};
        fns = '{6'b000000, 6'b111111};
        foreach (ops[k]) begin
            drive_instr(ops[k], fns[k], 1'b1);
            gen(ops[k], fns[k], 1'b1, 0, 0);
            foreach (exp_q[i]) begin
                step(exp_q[i].mrdy, exp_q[i].rnd, obs);
                n_checks++;
                if (obs !== exp_q[i].o) begin
                    n_fail++;
                    $display("[TB] FAIL illegal op=%b cycle %0d: got %b expected %b", ops[k], i, obs, exp_q[i].o);
                end
            end
            n_checks++;
            if (bus.retired !== exp_ret) begin
                n_fail++;
                $display("[TB] FAIL illegal_retired op=%b: got %0d expected %0d", ops[k], bus.retired, exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid_lw();
        outs_t obs;
        outs_t idle;
        drive_instr(6'b100011, 6'b000000, 1'b0);
        gen(6'b100011, 6'b000000, 1'b0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            step(exp_q[i].mrdy, exp_q[i].rnd, obs);
            n_checks++;
            if (obs !== exp_q[i].o) begin
                n_fail++;
                $display("[TB] FAIL mid_lw_pre cycle %0d: got %b expected %b", i, obs, exp_q[i].o);
            end
        end
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, obs);
            n_checks++;
            if (obs !== outs_t'('0)) begin
                n_fail++;
                $display("[TB] FAIL mid_lw_reset cycle %0d: got %b expected %b", i, obs, outs_t'('0));
            end
        end
        rstn = 1'b1;
        exp_ret = '0;
        n_checks++;
        if (bus.retired !== exp_ret) begin
            n_fail++;
            $display("[TB] FAIL mid_lw_retired: got %0d expected %0d", bus.retired, exp_ret);
        end
        idle = '0; idle.mr = 1'b1;
        step(1'b0, 1'b0, obs);
        n_checks++;
        if (obs !== idle) begin
            n_fail++;
            $display("[TB] FAIL mid_lw_fetch: got %b expected %b", obs, idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] lops [16];
        logic [5:0] lfns [16];
        logic [5:0] op;
        logic [5:0] fn;
        int         sel;
        outs_t      obs;
        lops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h23, 6'h2b};
        lfns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000,
                 6'b000010, 6'b001000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 99) < 15) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                sel = $urandom_range(0, 15);
                op  = lops[sel];
                fn  = (op == 6'h00) ? lfns[sel] : 6'($urandom);
            end
            drive_instr(op, fn, 1'($urandom_range(0, 1)));
            gen(op, fn, bus.Zero, $urandom_range(0, 2), $urandom_range(0, 2));
            foreach (exp_q[i]) begin
                step(exp_q[i].mrdy, exp_q[i].rnd, obs);
                n_checks++;
                if (obs !== exp_q[i].o) begin
                    n_fail++;
                    $display("[TB] FAIL random #%0d op=%b fn=%b cycle %0d: got %b expected %b", n, op, fn, i, obs, exp_q[i].o);
                end
            end
            n_checks++;
            if (bus.retired !== exp_ret) begin
                n_fail++;
                $display("[TB] FAIL random_retired #%0d: got %0d expected %0d", n, bus.retired, exp_ret);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_ret       = '0;
        rstn          = 1'b0;
        bus.mem_ready = 1'b0;
        drive_instr(6'b000000, 6'b000000, 1'b0);
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_lw();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
